rns_mult_sched: RTL and testbench

- Sequencer for the shared pointwise RNS modular multiplier.
- Walks every (basis, limb, slot) triple of a polynomial product across the q, B and Ba bases. Issues one operand pair per cycle to a fixed-latency, non-stallable modmul pipe.
- Generates the matching write-back strobe and address MUL_LAT cycles later. Signals completion to the upstream op controller.

---
 rtl/rns_mult_sched.sv | 141 ++++++++++++++
 tb/tb_rns_mult_sched.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rns_mult_sched.sv
// rns_mult_sched: sequences (basis, limb, slot) operand pairs into the shared modmul pipe and tracks write-back.
// Define RNS_MULT_SCHED_PERF_EN to add the perf_cycles / perf_stalls counters.
module rns_mult_sched #(
    parameter int N_SLOTS = 8,
    parameter int Q_LEN   = 2,
    parameter int B_LEN   = 3,
    parameter int BA_LEN  = 4,
    parameter int MUL_LAT = 3,
    parameter int SLOT_W  = $clog2(N_SLOTS),
    parameter int LIMB_W  = $clog2(Q_LEN > B_LEN ? (Q_LEN > BA_LEN ? Q_LEN : BA_LEN)
                                                 : (B_LEN > BA_LEN ? B_LEN : BA_LEN))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [2:0]        basis_mask,
    input  logic              hold,
    input  logic              abort,
    output logic              iss_valid,
    output logic [1:0]        iss_basis,
    output logic [LIMB_W-1:0] iss_limb,
    output logic [SLOT_W-1:0] iss_slot,
    output logic              wb_valid,
    output logic [1:0]        wb_basis,
    output logic [LIMB_W-1:0] wb_limb,
    output logic [SLOT_W-1:0] wb_slot,
    output logic              busy,
    output logic              done,
    output logic              aborted
`ifdef RNS_MULT_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [15:0]       perf_stalls
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef struct packed {
        logic              v;
        logic [1:0]        b;
        logic [LIMB_W-1:0] l;
        logic [SLOT_W-1:0] s;
    } ent_t;

    state_t state, state_nx;
    logic [2:0] mask;
    logic [1:0] basis, first_basis, next_basis, top_basis;
    logic [LIMB_W-1:0] limb, limb_max;
    logic [SLOT_W-1:0] slot;
    logic accept, issue, last_slot, last_limb, last, pipe_busy, abort_q;
    ent_t iss_q;
    ent_t pipe [MUL_LAT];

    always_comb begin
        accept      = start_valid && state == IDLE;
        issue       = state == ISSUE && !abort && !hold;
        first_basis = basis_mask[0] ? 2'd0 : basis_mask[1] ? 2'd1 : 2'd2;
        next_basis  = (basis == 2'd0 && mask[1]) ? 2'd1 : 2'd2;
        top_basis   = mask[2] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
        limb_max    = basis == 2'd0 ? LIMB_W'(Q_LEN - 1) : basis == 2'd1 ? LIMB_W'(B_LEN - 1) : LIMB_W'(BA_LEN - 1);
        last_slot   = slot == SLOT_W'(N_SLOTS - 1);
        last_limb   = limb == limb_max;
        last        = last_slot && last_limb && basis == top_basis;
        // the entry reaching wb this cycle is the last one that matters; DONE follows it
        pipe_busy   = iss_q.v;
        for (int i = 0; i < MUL_LAT - 1; i++)
            pipe_busy = pipe_busy | pipe[i].v;
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (basis_mask == 3'b000 ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nx = (abort || (issue && last)) ? DRAIN : ISSUE;
            DRAIN:   state_nx = pipe_busy ? DRAIN : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mask    <= '0;
            basis   <= '0;
            limb    <= '0;
            slot    <= '0;
            abort_q <= 1'b0;
            iss_q   <= '0;
            for (int i = 0; i < MUL_LAT; i++)
                pipe[i] <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                mask    <= basis_mask;
                basis   <= first_basis;
                limb    <= '0;
                slot    <= '0;
                abort_q <= 1'b0;
            end else if (issue) begin
                slot <= last_slot ? '0 : slot + 1'b1;
                if (last_slot)
                    limb <= last_limb ? '0 : limb + 1'b1;
                if (last_slot && last_limb)
                    basis <= next_basis;
            end
            if (state == ISSUE && abort)
                abort_q <= 1'b1;
            iss_q   <= issue ? {1'b1, basis, limb, slot} : '0;
            pipe[0] <= iss_q;
            for (int i = 1; i < MUL_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign start_ready = state == IDLE;
    assign busy        = state == ISSUE || state == DRAIN;
    assign done        = state == DONE;
    assign aborted     = done && abort_q;
    assign iss_valid   = iss_q.v;
    assign iss_basis   = iss_q.b;
    assign iss_limb    = iss_q.l;
    assign iss_slot    = iss_q.s;
    assign wb_valid    = pipe[MUL_LAT-1].v;
    assign wb_basis    = pipe[MUL_LAT-1].b;
    assign wb_limb     = pipe[MUL_LAT-1].l;
    assign wb_slot     = pipe[MUL_LAT-1].s;

`ifdef RNS_MULT_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (accept) begin
            perf_cycles <= 32'd1;
            perf_stalls <= '0;
        end else begin
            if (busy && perf_cycles != '1)
                perf_cycles <= perf_cycles + 1'b1;
            if (state == ISSUE && hold && perf_stalls != '1)
                perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rns_mult_sched.sv
// tb_rns_mult_sched: scoreboard bench for rns_mult_sched; issue order from a model, wb checked against queued expectations.
module tb_rns_mult_sched;
    localparam int N = 8, QL = 2, BL = 3, BAL = 4, LAT = 3, SW = 3, LW = 2;

    logic clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, hold = 1'b0, abort = 1'b0;
    logic [2:0] basis_mask = '0;
    logic start_ready, iss_valid, wb_valid, busy, done, aborted;
    logic [1:0] iss_basis, wb_basis;
    logic [LW-1:0] iss_limb, wb_limb;
    logic [SW-1:0] iss_slot, wb_slot;
`ifdef RNS_MULT_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [15:0] perf_stalls;
`endif

    always #5 clk = ~clk;

    rns_mult_sched dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .basis_mask(basis_mask), .hold(hold), .abort(abort),
        .iss_valid(iss_valid), .iss_basis(iss_basis), .iss_limb(iss_limb), .iss_slot(iss_slot),
        .wb_valid(wb_valid), .wb_basis(wb_basis), .wb_limb(wb_limb), .wb_slot(wb_slot),
        .busy(busy), .done(done), .aborted(aborted)
`ifdef RNS_MULT_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int n_cmp = 0, n_err = 0;
    logic [6:0] exp_iss[$];
    logic [6:0] wb_q[$];
    int wb_due[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int blen(input int b);
        return b == 0 ? QL : b == 1 ? BL : BAL;
    endfunction

    // h0..h1: edges with hold; ab: abort edge; rs: edge before which reset hits (-1 = none)
    task automatic run_op(input logic [2:0] m, input int h0, input int h1, input int ab, input int rs,
                          input bit keep_start, input int exp_n, input int exp_done, input int exp_stalls);
        int issued = 0;
        bit fin = 0, did_rst = 0, exp_v;
        logic [6:0] e;
        exp_iss.delete(); wb_q.delete(); wb_due.delete();
        for (int b = 0; b < 3; b++)
            if (m[b])
                for (int l = 0; l < blen(b); l++)
                    for (int s = 0; s < N; s++)
                        exp_iss.push_back({2'(b), 2'(l), 3'(s)});
        for (int k = 0; k <= exp_done && !fin; k++) begin
            @(negedge clk);
            start_valid = (k == 0) || keep_start;
            basis_mask  = m;
            hold        = k >= h0 && k <= h1;
            abort       = k == ab;
            if (k == rs) begin
                rst_n = 1'b0;
                #1;
                check("rst_outputs", {iss_valid, wb_valid, busy, done, aborted}, 5'b0);
                check("rst_ready", start_ready, 1'b1);
                did_rst = 1;
                fin = 1;
            end else begin
                @(posedge clk); #1;
                exp_v = k >= 1 && (ab < 0 || k < ab) && issued < exp_n && !hold;
                check("iss_valid", iss_valid, exp_v);
                if (iss_valid) begin
                    e = exp_iss.size() > 0 ? exp_iss.pop_front() : 7'h7f;
                    check("iss_idx", {iss_basis, iss_limb, iss_slot}, e);
                    wb_q.push_back(e);
                    wb_due.push_back(k + LAT);
                    issued++;
                end
                if (wb_valid) begin
                    if (wb_q.size() == 0)
                        check("wb_spurious", wb_valid, 1'b0);
                    else begin
                        check("wb_idx", {wb_basis, wb_limb, wb_slot}, wb_q.pop_front());
                        check("wb_lag", k, wb_due.pop_front());
                    end
                end
                check("start_ready", start_ready, 1'b0);
                check("busy", busy, k < exp_done);
                check("done", done, k == exp_done);
                if (k == exp_done) begin
                    check("aborted", aborted, ab >= 0);
                    check("n_issued", issued, exp_n);
                    check("wb_drained", wb_q.size(), 0);
`ifdef RNS_MULT_SCHED_PERF_EN
                    check("perf_cycles", perf_cycles, exp_done + 1);
                    check("perf_stalls", perf_stalls, exp_stalls);
`endif
                end
            end
        end
        @(negedge clk);
        start_valid = 1'b0; hold = 1'b0; abort = 1'b0;
        if (!did_rst) begin
            @(posedge clk); #1;
            check("idle_ready", {start_ready, busy, done}, 3'b100);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_outputs", {iss_valid, wb_valid, busy, done, aborted}, 5'b0);
        check("reset_ready", start_ready, 1'b1);
        rst_n = 1'b1;
        run_op(3'b111, -1, -1, -1, -1, 0, 72, 76, 0);
        run_op(3'b101, -1, -1, -1, -1, 0, 48, 52, 0);
        run_op(3'b001,  3,  5, -1, -1, 0, 16, 23, 3);
        run_op(3'b111, -1, -1, 10, -1, 0,  9, 13, 0);
        run_op(3'b000, -1, -1, -1, -1, 0,  0,  0, 0);
        run_op(3'b001, -1, -1, -1, -1, 1, 16, 20, 0);
        run_op(3'b111, -1, -1, -1, 20, 0, 72, 76, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {iss_valid, wb_valid, done, busy, start_ready}, 5'b00001);
        end
        run_op(3'b111, -1, -1, -1, -1, 0, 72, 76, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
